instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the pipelined CPU: drives the 16-bit program counter into the combinational instruction ROM and captures the returned 9-bit instruction into the IF/ID pipeline register. It handles pipeline stalls and branch/jump redirects, and stops fetching once a `halt` opcode has been fetched. The block sits between the instruction ROM and the decode stage; redirects come from the branch-resolution logic downstream.

## Interface
Parameters:
- `RESET_PC`, 16'd1: PC value after reset. Programs start at address 1.
- `HALT_OP`, 5'b11010: opcode that stops fetch.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `pc`, out, 16: fetch address to the instruction ROM. Registered.
- `instruction`, in, 9: ROM data, combinational from `pc`. Bits [8:4] are the opcode; bits [3:0] are the operand.
- `stall`, in, 1: decode cannot accept; hold all state.
- `redirect_valid`, in, 1: branch/jump taken; flush and reload the PC.
- `redirect_pc`, in, 16: new fetch address.
- `if_valid`, out, 1: IF/ID register holds a live instruction.
- `if_instr`, out, 9: fetched instruction.
- `if_pc`, out, 16: address `if_instr` was fetched from.
- `halted`, out, 1: fetch stopped on `halt`.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Reset values (async, on `rst_n` low):
  - `pc` = RESET_PC
  - `if_valid` = 0
  - `if_instr` = 0
  - `if_pc` = 0
  - `halted` = 0
- Priority per edge: redirect_valid > stall > normal fetch.
- Redirect, in either state:
  - `pc` <= `redirect_pc`
  - `if_valid` <= 0 (the wrong-path instruction is flushed)
  - state <= RUN; `halted` clears
  - A redirect overrides a simultaneous stall.
- Stall with no redirect: `pc`, `if_*` and state all hold.
- RUN, no stall, no redirect:
  - `if_instr` <= `instruction`, `if_pc` <= `pc`, `if_valid` <= 1.
  - If `instruction[8:4]` == HALT_OP: `pc` holds and state <= HALTED. The halt itself is delivered downstream.
  - Otherwise `pc` <= `pc` + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- HALTED, no stall, no redirect: `if_valid` <= 0, and `pc` and `if_instr` hold. The ROM is not re-sampled.
- `halted` = (state == HALTED).
- A speculatively fetched halt that is later flushed by a redirect resumes fetching at `redirect_pc`.

## Timing
- ROM lookup is combinational in the same cycle. Fetch-to-`if_valid` latency is 1 cycle.
- First instruction: in the first edge after `rst_n` rises, `if_instr` = ROM[RESET_PC] and `pc` = RESET_PC+1.
- Redirect penalty: the edge that takes the redirect produces one bubble (`if_valid`=0). The instruction at `redirect_pc` appears on the following edge.
- `halted` rises on the same edge that `if_instr` becomes the halt instruction.
- Stall is sampled every edge with no skid. Decode must hold its own state while `stall` is high.
- Asserting `rst_n` low mid-operation immediately forces all reset values, independent of `clk`.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - Widths: INSTR_W=9, OPCODE_W=5, OPERAND_W=4, PC_W=16.
  - The full opcode list (add…halt, toBeDefined).
  - The fetch state enum. This block uses HALT_OP from the package by default.
- Flat implementation; no sub-module is natural. The PC incrementer and the IF/ID register are each a single always block.

## Test plan
- Reset with a behavioural ROM {1: seti 0001, 2: mathToAdr 0000, 3: zeroReg 0001, others: halt}. Release reset, then:
  - `if_instr`/`if_pc` step through (9'h61,1), (9'h90,2), (9'h191,3), (halt,4).
  - `halted`=1 at the 4th edge; `pc` stays 4.
  - `if_valid`=0 from the 5th edge.
- Stall for 3 cycles mid-program: `pc`, `if_instr`, `if_pc` and `if_valid` are frozen; fetch resumes with no skipped or duplicated address.
- Redirect to 16'h0010 while stall=1: the next edge gives `if_valid`=0 and `pc`=16'h0010. The edge after that gives `if_pc`=16'h0010.
- While HALTED, redirect to 1: `halted`=0 on that edge, and fetch restarts from address 1.
- Redirect to 16'hFFFF with a non-halt instruction there: `if_pc`=16'hFFFF, then `pc`=16'h0000 (wrap).
- Pull `rst_n` low asynchronously between clock edges mid-program: outputs reach reset values before the next `clk` edge, and `pc`=1.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions for the pipelined CPU.
//   - Instruction field widths and PC width.
//   - The opcode list. The encoding occupies instruction bits [8:4].
//   - The fetch-stage state enum.
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

  localparam int INSTR_W   = 9;
  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 4;
  localparam int PC_W      = 16;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD           = 5'd0,
    OP_SUB           = 5'd1,
    OP_AND           = 5'd2,
    OP_OR            = 5'd3,
    OP_XOR           = 5'd4,
    OP_SHL           = 5'd5,
    OP_SETI          = 5'd6,
    OP_LOAD          = 5'd7,
    OP_STORE         = 5'd8,
    OP_MATH_TO_ADR   = 5'd9,
    OP_ADR_TO_MATH   = 5'd10,
    OP_INC           = 5'd11,
    OP_DEC           = 5'd12,
    OP_CMP           = 5'd13,
    OP_JMP           = 5'd14,
    OP_JZ            = 5'd15,
    OP_JNZ           = 5'd16,
    OP_JC            = 5'd17,
    OP_CALL          = 5'd18,
    OP_RET           = 5'd19,
    OP_PUSH          = 5'd20,
    OP_POP           = 5'd21,
    OP_IN            = 5'd22,
    OP_OUT           = 5'd23,
    OP_NOP           = 5'd24,
    OP_ZERO_REG      = 5'd25,
    OP_HALT          = 5'd26,
    OP_TO_BE_DEFINED = 5'd27
  } opcode_e;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage. Drives the PC into a combinational instruction ROM and captures
// the returned instruction into the IF/ID pipeline register. Handles stalls,
// branch/jump redirects, and stops fetching once a halt opcode is fetched.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pc             out  fetch address to the ROM (registered)
//   instruction    in   ROM data for pc; [8:4] opcode, [3:0] operand
//   stall          in   decode cannot accept; hold all state
//   redirect_valid in   taken branch/jump; flush IF/ID and reload the PC
//   redirect_pc    in   new fetch address
//   if_valid       out  IF/ID register holds a live instruction
//   if_instr       out  fetched instruction
//   if_pc          out  address if_instr was fetched from
//   halted         out  fetch stopped on halt
// -----------------------------------------------------------------------------
module instruction_fetch
  import cpu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0]     RESET_PC = 16'd1,
  parameter logic [OPCODE_W-1:0] HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               halted
);

  fetch_state_e        state_q,    state_d;
  logic [PC_W-1:0]     pc_q,       pc_d;
  logic                if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
  logic [PC_W-1:0]     if_pc_q,    if_pc_d;

  logic is_halt;
  assign is_halt = (instruction[INSTR_W-1:OPERAND_W] == HALT_OP);

  // Priority: redirect > stall > fetch.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (redirect_valid) begin
      // Flush the wrong-path instruction; a redirect also revives a halted
      // fetch, which covers a halt fetched speculatively past a branch.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      state_d    = FS_RUN;
    end else if (!stall) begin
      unique case (state_q)
        FS_RUN: begin
          if_instr_d = instruction;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (is_halt) begin
            state_d = FS_HALTED;       // pc parks on the halt address
          end else begin
            pc_d = pc_q + 16'd1;       // wraps 16'hFFFF -> 16'h0000
          end
        end
        FS_HALTED: begin
          if_valid_d = 1'b0;           // ROM is not re-sampled
        end
        default: begin
          state_d = FS_RUN;
        end
      endcase
    end
  end

  // PC and fetch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge value of every other register.
      pc_q    <= RESET_PC;
      state_q <= FS_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload fields are reset too, not just the valid bit, so
      // downstream sees deterministic values straight out of reset.
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign pc       = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign halted   = (state_q == FS_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a behavioural ROM. Each step pushes
// the expected post-edge view onto a scoreboard queue; after the edge the entry
// is popped and compared field by field.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
  import cpu_isa_pkg::*;

  localparam logic [8:0] I_SETI  = 9'h061;  // seti 0001
  localparam logic [8:0] I_M2A   = 9'h090;  // mathToAdr 0000
  localparam logic [8:0] I_ZERO  = 9'h191;  // zeroReg 0001
  localparam logic [8:0] I_HALT  = 9'h1A0;  // halt 0000
  localparam logic [8:0] I_ADD   = 9'h003;  // add 0011

  typedef struct packed {
    logic [15:0] pc;
    logic        valid;
    logic [8:0]  instr;
    logic [15:0] ipc;
    logic        halted;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [8:0]  instruction;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [8:0]  if_instr;
  logic [15:0] if_pc;
  logic        halted;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instruction    (instruction),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  function automatic logic [8:0] rom(input logic [15:0] addr);
    case (addr)
      16'h0001: rom = I_SETI;
      16'h0002: rom = I_M2A;
      16'h0003: rom = I_ZERO;
      16'hFFFF: rom = I_ADD;
      default:  rom = I_HALT;
    endcase
  endfunction

  assign instruction = rom(pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_view(input string tag, input exp_t e);
    check({tag, ".pc"},       32'(pc),       32'(e.pc));
    check({tag, ".if_valid"}, 32'(if_valid), 32'(e.valid));
    check({tag, ".if_instr"}, 32'(if_instr), 32'(e.instr));
    check({tag, ".if_pc"},    32'(if_pc),    32'(e.ipc));
    check({tag, ".halted"},   32'(halted),   32'(e.halted));
  endtask

  // Drive one cycle of inputs, record the expectation, clock, then compare.
  task automatic step(input string tag, input logic st, input logic rv,
                      input logic [15:0] rpc, input exp_t e);
    exp_t got;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      check_view(tag, got);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    @(posedge clk);
    #1;
    check_view("reset", '{16'h0001, 1'b0, 9'h000, 16'h0000, 1'b0});
    #3 rst_n = 1'b1;  // release between edges

    // Straight-line program up to halt.
    step("f1",   0, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});
    step("f2",   0, 0, 0, '{16'h0003, 1'b1, I_M2A,  16'h0002, 1'b0});
    step("f3",   0, 0, 0, '{16'h0004, 1'b1, I_ZERO, 16'h0003, 1'b0});
    step("f4",   0, 0, 0, '{16'h0004, 1'b1, I_HALT, 16'h0004, 1'b1});
    step("h5",   0, 0, 0, '{16'h0004, 1'b0, I_HALT, 16'h0004, 1'b1});
    step("h6",   0, 0, 0, '{16'h0004, 1'b0, I_HALT, 16'h0004, 1'b1});

    // Redirect out of HALTED back to address 1.
    step("rd1",  0, 1, 16'h0001, '{16'h0001, 1'b0, I_HALT, 16'h0004, 1'b0});
    step("rf1",  0, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});

    // Three-cycle stall mid-program: everything frozen.
    step("st1",  1, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});
    step("st2",  1, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});
    step("st3",  1, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});
    step("rf2",  0, 0, 0, '{16'h0003, 1'b1, I_M2A,  16'h0002, 1'b0});
    step("rf3",  0, 0, 0, '{16'h0004, 1'b1, I_ZERO, 16'h0003, 1'b0});
    step("rf4",  0, 0, 0, '{16'h0004, 1'b1, I_HALT, 16'h0004, 1'b1});

    // Redirect wins over a simultaneous stall.
    step("rds",  1, 1, 16'h0010, '{16'h0010, 1'b0, I_HALT, 16'h0004, 1'b0});
    step("r10",  0, 0, 0, '{16'h0010, 1'b1, I_HALT, 16'h0010, 1'b1});
    step("h10",  0, 0, 0, '{16'h0010, 1'b0, I_HALT, 16'h0010, 1'b1});

    // PC wrap from 16'hFFFF.
    step("rdf",  0, 1, 16'hFFFF, '{16'hFFFF, 1'b0, I_HALT, 16'h0010, 1'b0});
    step("wrap", 0, 0, 0, '{16'h0000, 1'b1, I_ADD,  16'hFFFF, 1'b0});
    step("f0",   0, 0, 0, '{16'h0000, 1'b1, I_HALT, 16'h0000, 1'b1});

    // Restart, then async reset between edges.
    step("rd2",  0, 1, 16'h0001, '{16'h0001, 1'b0, I_HALT, 16'h0000, 1'b0});
    step("g1",   0, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});
    step("g2",   0, 0, 0, '{16'h0003, 1'b1, I_M2A,  16'h0002, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check_view("async_rst", '{16'h0001, 1'b0, 9'h000, 16'h0000, 1'b0});
    #3 rst_n = 1'b1;
    step("p1",   0, 0, 0, '{16'h0002, 1'b1, I_SETI, 16'h0001, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
